// File: rtl/wishbone_ram_slave.sv
// wishbone_ram_slave: Wishbone classic-cycle responder backed by a word-addressed RAM.
// A request seen at an idle edge is answered after WAIT_STATES extra cycles with one
// registered ack pulse. Writes honour byte lanes. Dropping cyc or stb while waiting
// abandons the transfer without touching the RAM or the outputs.
// A strobe still high after a response must be seen low at an edge before the next
// transfer is accepted, so a stuck strobe is answered once only.
// Optional feature: define WB_RAM_ERR_EN to answer out-of-window addresses with a
// wb_err_o pulse. Without it, wb_err_o is tied low and out-of-window addresses alias.
module wishbone_ram_slave #(
  parameter int unsigned DEPTH_LOG2  = 12,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] wb_data_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    hold_q, hold_d;
  logic                    we_q;
  logic [3:0]              sel_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [31:0]             data_q;

  logic                    req;
  logic                    latch_en;
  logic                    enter_resp;
  logic [31:0]             offset;
  logic [DEPTH_LOG2-1:0]   idx_in;
  logic                    cur_we;
  logic [3:0]              cur_sel;
  logic [DEPTH_LOG2-1:0]   cur_idx;
  logic [31:0]             cur_data;
  logic                    resp_err;
  logic                    do_write;
  logic                    do_read;

  logic [31:0]             mem [DEPTH];

  assign req    = wb_cyc_i & wb_stb_i;
  assign offset = wb_addr_i - BASE_ADDR;
  assign idx_in = DEPTH_LOG2'(offset >> 2);

  // With zero wait states the RAM is accessed on the request edge itself, so the
  // live bus fields are used in IDLE; otherwise the fields latched at the request.
  assign cur_we   = (state_q == IDLE) ? wb_we_i   : we_q;
  assign cur_sel  = (state_q == IDLE) ? wb_sel_i  : sel_q;
  assign cur_idx  = (state_q == IDLE) ? idx_in    : idx_q;
  assign cur_data = (state_q == IDLE) ? wb_data_i : data_q;

`ifdef WB_RAM_ERR_EN
  logic inr_in, inr_q, cur_inr;
  assign inr_in   = {1'b0, offset} < (33'd4 << DEPTH_LOG2);
  assign cur_inr  = (state_q == IDLE) ? inr_in : inr_q;
  assign resp_err = ~cur_inr;
`else
  assign resp_err = 1'b0;
`endif

  // The RAM is never written while reset is held, so a reset discards any transfer.
  assign do_write = enter_resp & cur_we & ~resp_err & rst;
  assign do_read  = enter_resp & ~cur_we & ~resp_err;

  // Next-state logic: accept, count wait states, abort, respond once.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = 1'b0;
    latch_en   = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        hold_d = hold_q & req;
        if (req && !hold_q) begin
          latch_en = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WS;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        hold_d  = req;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and request capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      if (latch_en) begin
        we_q   <= wb_we_i;
        sel_q  <= wb_sel_i;
        idx_q  <= idx_in;
        data_q <= wb_data_i;
      end
    end
  end

`ifdef WB_RAM_ERR_EN
  // Range flag travels with the latched request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inr_q <= 1'b0;
    end else if (latch_en) begin
      inr_q <= inr_in;
    end
  end

  // Error pulse for out-of-window requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_err_o <= 1'b0;
    end else begin
      wb_err_o <= enter_resp & resp_err;
    end
  end
`else
  assign wb_err_o = 1'b0;
`endif

  // Byte-lane RAM write on the edge that enters RESP.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset so it maps onto block RAM; contents survive reset.
    for (int b = 0; b < 4; b++) begin
      if (do_write && cur_sel[b]) begin
        mem[cur_idx][8*b +: 8] <= cur_data[8*b +: 8];
      end
    end
  end

  // Registered ack and read data; read data holds until the next successful read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ack_o  <= 1'b0;
      wb_data_o <= '0;
    end else begin
      wb_ack_o <= enter_resp & ~resp_err;
      if (do_read) begin
        wb_data_o <= mem[cur_idx];
      end
    end
  end

endmodule

// File: tb/tb_wishbone_ram_slave.sv
// Bench for wishbone_ram_slave: three instances (0, 1 and 3 wait states, one with a
// non-zero base) driven one transfer at a time. A transaction-level model predicts the
// response cycle, ack/err and read data; one process compares every cycle.
module tb_wishbone_ram_slave;

  localparam int N = 3;
  localparam int unsigned WS_T [N]   = '{0, 1, 3};
  localparam logic [31:0] BASE_T [N] = '{32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
`ifdef WB_RAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc  [N];
  logic        stb  [N];
  logic        we   [N];
  logic [3:0]  sel  [N];
  logic [31:0] addr [N];
  logic [31:0] wdat [N];
  logic [31:0] rdat [N];
  logic        ack  [N];
  logic        err  [N];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_dut
      wishbone_ram_slave #(
        .DEPTH_LOG2 (12),
        .WAIT_STATES(WS_T[g]),
        .BASE_ADDR  (BASE_T[g])
      ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .wb_cyc_i (cyc[g]),
        .wb_stb_i (stb[g]),
        .wb_we_i  (we[g]),
        .wb_sel_i (sel[g]),
        .wb_addr_i(addr[g]),
        .wb_data_i(wdat[g]),
        .wb_data_o(rdat[g]),
        .wb_ack_o (ack[g]),
        .wb_err_o (err[g])
      );
    end
  endgenerate

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: RAM image per instance plus the predicted response timeline.
  logic [31:0] mem_m [N][4096];
  logic [31:0] exp_data  [N];
  logic [31:0] pend_data [N];
  int          pend_cyc  [N];
  int          resp_cyc  [N];
  bit          resp_err  [N];
  int          ack_cnt   [N];
  int          cyc_cnt = 0;
  bit          cmp_en  = 1'b0;
  bit          ea_v, ee_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) if (ack[i] === 1'b1) ack_cnt[i]++;
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < N; i++) begin
        if (cyc_cnt == pend_cyc[i]) exp_data[i] = pend_data[i];
        ea_v = (cyc_cnt == resp_cyc[i]) && !resp_err[i];
        ee_v = (cyc_cnt == resp_cyc[i]) && resp_err[i];
        check($sformatf("ack%0d@%0d", i, cyc_cnt), 32'(ack[i]), 32'(ea_v));
        check($sformatf("err%0d@%0d", i, cyc_cnt), 32'(err[i]), 32'(ee_v));
        check($sformatf("data%0d@%0d", i, cyc_cnt), rdat[i], exp_data[i]);
      end
    end
  end

  // One master transfer. abort_j > 0 drops cyc/stb after that many cycles (in WAIT).
  // hold_extra keeps stb high for extra cycles after the ack.
  task automatic xfer(input int i, input bit w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] d, input int abort_j, input int hold_extra,
                      output bit saw_err);
    logic [31:0] off;
    int          idx;
    bit          oor;
    int          rc;
    int          lat;
    @(negedge clk);
    off = a - BASE_T[i];
    idx = int'(off[13:2]);
    oor = (off >= 32'h0000_4000);
    rc  = cyc_cnt + 1 + int'(WS_T[i]);
    lat = -1;
    saw_err = 1'b0;
    if (abort_j == 0) begin
      resp_cyc[i] = rc;
      resp_err[i] = ERR_EN && oor;
      if (!(ERR_EN && oor)) begin
        if (w) begin
          for (int b = 0; b < 4; b++) if (s[b]) mem_m[i][idx][8*b +: 8] = d[8*b +: 8];
        end else begin
          pend_data[i] = mem_m[i][idx];
          pend_cyc[i]  = rc;
        end
      end
    end
    cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; sel[i] = s; addr[i] = a; wdat[i] = d;
    if (abort_j > 0) begin
      repeat (abort_j) @(negedge clk);
      cyc[i] = 1'b0; stb[i] = 1'b0;
    end else begin
      for (int n = 1; n <= int'(WS_T[i]) + 4; n++) begin
        @(negedge clk);
        if (ack[i] === 1'b1 || err[i] === 1'b1) begin
          lat = n;
          saw_err = (err[i] === 1'b1);
          break;
        end
      end
      check($sformatf("latency%0d", i), 32'(lat), 32'(int'(WS_T[i]) + 1));
      repeat (hold_extra) @(negedge clk);
      @(posedge clk); #1;
      cyc[i] = 1'b0; stb[i] = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bit          e;
    int          a0;
    int          i, r, widx, ws;
    logic [31:0] a;

    for (int k = 0; k < N; k++) begin
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0; sel[k] = '0; addr[k] = '0; wdat[k] = '0;
      exp_data[k] = '0; pend_cyc[k] = -1; resp_cyc[k] = -1; resp_err[k] = 1'b0; ack_cnt[k] = 0;
    end

    // Reset state.
    #1 rst = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst_ack%0d", k), 32'(ack[k]), 32'd0);
      check($sformatf("rst_err%0d", k), 32'(err[k]), 32'd0);
      check($sformatf("rst_data%0d", k), rdat[k], 32'd0);
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    cmp_en = 1'b1;

    // Test 1: one wait state, write then read back.
    xfer(1, 1'b1, 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, e);
    xfer(1, 1'b0, 4'b1111, 32'h0000_0010, 32'h0, 0, 0, e);
    check("t1_rdata", rdat[1], 32'hDEAD_BEEF);

    // Test 2: byte lanes.
    xfer(1, 1'b1, 4'b1111, 32'h0000_0014, 32'h1122_3344, 0, 0, e);
    xfer(1, 1'b1, 4'b0101, 32'h0000_0014, 32'hAABB_CCDD, 0, 0, e);
    xfer(1, 1'b0, 4'b1111, 32'h0000_0014, 32'h0, 0, 0, e);
    check("t2_lanes", rdat[1], 32'h11BB_33DD);

    // Test 3: abort during WAIT with three wait states.
    xfer(2, 1'b1, 4'b1111, BASE_T[2] + 32'h20, 32'h0000_1234, 0, 0, e);
    a0 = ack_cnt[2];
    xfer(2, 1'b1, 4'b1111, BASE_T[2] + 32'h20, 32'h0000_0005, 2, 0, e);
    repeat (6) @(negedge clk);
    check("t3_no_ack", 32'(ack_cnt[2] - a0), 32'd0);
    xfer(2, 1'b0, 4'b1111, BASE_T[2] + 32'h20, 32'h0, 0, 0, e);
    check("t3_prior", rdat[2], 32'h0000_1234);

    // Test 4a: zero wait states, stb held through three edges gives one ack.
    a0 = ack_cnt[0];
    xfer(0, 1'b1, 4'b1111, 32'h0000_0040, 32'h0000_0077, 0, 1, e);
    check("t4_one_ack", 32'(ack_cnt[0] - a0), 32'd1);

    // Test 4b: reset while instance 2 sits in WAIT.
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF;
    addr[2] = BASE_T[2] + 32'h20; wdat[2] = 32'h0000_0005;
    @(negedge clk);
    #2;
    for (int k = 0; k < N; k++) begin
      exp_data[k] = '0; resp_cyc[k] = -1; pend_cyc[k] = -1;
    end
    rst = 1'b0;
    #1;
    check("t4_rst_ack", 32'(ack[2]), 32'd0);
    check("t4_rst_err", 32'(err[2]), 32'd0);
    check("t4_rst_data", rdat[1], 32'd0);
    cyc[2] = 1'b0; stb[2] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    xfer(2, 1'b0, 4'b1111, BASE_T[2] + 32'h20, 32'h0, 0, 0, e);
    check("t4_no_write", rdat[2], 32'h0000_1234);

    // Test 5: window edge and out-of-window handling.
    xfer(1, 1'b1, 4'b1111, 32'h0000_3FFC, 32'hCAFE_F00D, 0, 0, e);
    xfer(1, 1'b1, 4'b1111, 32'h0000_0000, 32'h0BAD_BEEF, 0, 0, e);
    xfer(1, 1'b0, 4'b1111, 32'h0000_0010, 32'h0, 0, 0, e);
    xfer(1, 1'b0, 4'b1111, 32'h0000_4000, 32'h0, 0, 0, e);
    check("t5_oor_err", 32'(e), 32'(ERR_EN));
    check("t5_oor_data", rdat[1], ERR_EN ? 32'hDEAD_BEEF : 32'h0BAD_BEEF);
    xfer(1, 1'b0, 4'b1111, 32'h0000_3FFC, 32'h0, 0, 0, e);
    check("t5_top_err", 32'(e), 32'd0);
    check("t5_top_data", rdat[1], 32'hCAFE_F00D);

    // Fill the words used by random traffic (indices 0..31 and 4092..4095).
    for (int k = 0; k < N; k++) begin
      for (int w = 0; w < 36; w++) begin
        widx = (w < 32) ? w : 4060 + w;
        xfer(k, 1'b1, 4'b1111, BASE_T[k] + 32'(widx * 4), $urandom, 0, 0, e);
      end
    end

    // Random traffic: mixed reads/writes, lanes, aliases, wrap below base, aborts.
    for (int t = 0; t < 400; t++) begin
      i    = int'($urandom_range(0, N - 1));
      ws   = int'(WS_T[i]);
      widx = int'($urandom_range(0, 35));
      widx = (widx < 32) ? widx : 4060 + widx;
      r    = int'($urandom_range(0, 3));
      a    = BASE_T[i] + 32'(widx * 4) + 32'($urandom_range(0, 3));
      if (r == 2) a = a + 32'h0000_4000 * $urandom_range(1, 3);
      if (r == 3 && widx >= 4092) a = a - 32'h0000_4000;
      xfer(i, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom,
           (ws > 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, ws)) : 0,
           int'($urandom_range(0, 1)), e);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
